// File: rtl/prbs64_checker.sv
// prbs64_checker
//   Receive-side checker for a 64-bit XNOR PRBS (taps 64,63,61,60):
//   new bit = s[63] ~^ s[62] ~^ s[60] ~^ s[59], shifted into s[0].
//   Loads 64 received bits in FILL, then runs its own generator in LOCKED
//   and compares every valid bit against the prediction. Too many errors in
//   one evaluation window drops it back to FILL.
// Ports
//   clk, reset (async, active low)
//   bit_in, bit_valid    received stream bit and its qualifier
//   clear                synchronous clear of err_count / resync_count
//   locked               registered "synchronized" flag
//   err_pulse            one-cycle pulse per mismatched bit
//   err_count            saturating mismatch count while locked
//   resync_count         saturating count of error-driven LOCKED->FILL exits
module prbs64_checker #(
    parameter int ERR_THRESH = 8,
    parameter int WINDOW     = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [31:0] err_count,
    output logic [15:0] resync_count
);
    typedef enum logic {FILL = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
    localparam logic [15:0] THRESH   = 16'(ERR_THRESH);

    state_t      state, state_n;
    logic [63:0] r, r_n;
    logic [5:0]  fill_cnt, fill_n;
    logic [15:0] wbits, wbits_n;
    logic [15:0] werrs, werrs_n;
    logic        pulse_n;
    logic [31:0] errc_n;
    logic [15:0] rsc_n;

    logic        pred, mism;
    logic [15:0] werrs_inc;
    logic [63:0] fill_shift;

    assign pred       = ~(r[63] ^ r[62] ^ r[60] ^ r[59]);
    assign mism       = bit_in ^ pred;
    assign werrs_inc  = werrs + 16'(mism);
    assign fill_shift = {r[62:0], bit_in};

    always_comb begin
        state_n = state;
        r_n     = r;
        fill_n  = fill_cnt;
        wbits_n = wbits;
        werrs_n = werrs;
        pulse_n = 1'b0;
        errc_n  = err_count;
        rsc_n   = resync_count;
        if (bit_valid) begin
            case (state)
                FILL: begin
                    r_n = fill_shift;
                    if (fill_cnt == 6'd63) begin
                        fill_n = 6'd0;
                        // All ones is the XNOR generator's lock-up state:
                        // a stuck-high line would otherwise look locked.
                        if (fill_shift != '1) begin
                            state_n = LOCKED;
                            wbits_n = 16'd0;
                            werrs_n = 16'd0;
                        end
                    end else begin
                        fill_n = fill_cnt + 6'd1;
                    end
                end
                LOCKED: begin
                    // Self-running: shift in the prediction so a line error
                    // produces one mismatch rather than a burst.
                    r_n     = {r[62:0], pred};
                    pulse_n = mism;
                    if (mism && err_count != '1)
                        errc_n = err_count + 32'd1;
                    // Threshold check wins over the window rollover.
                    if (mism && werrs_inc >= THRESH) begin
                        state_n = FILL;
                        fill_n  = 6'd0;
                        wbits_n = 16'd0;
                        werrs_n = 16'd0;
                        if (resync_count != '1)
                            rsc_n = resync_count + 16'd1;
                    end else if (wbits == WIN_LAST) begin
                        wbits_n = 16'd0;
                        werrs_n = 16'd0;
                    end else begin
                        wbits_n = wbits + 16'd1;
                        werrs_n = werrs_inc;
                    end
                end
                default: state_n = FILL;
            endcase
        end
        if (clear) begin
            errc_n = 32'd0;
            rsc_n  = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= FILL;
            r            <= '0;
            fill_cnt     <= '0;
            wbits        <= '0;
            werrs        <= '0;
            locked       <= 1'b0;
            err_pulse    <= 1'b0;
            err_count    <= '0;
            resync_count <= '0;
        end else begin
            state        <= state_n;
            r            <= r_n;
            fill_cnt     <= fill_n;
            wbits        <= wbits_n;
            werrs        <= werrs_n;
            locked       <= (state_n == LOCKED);
            err_pulse    <= pulse_n;
            err_count    <= errc_n;
            resync_count <= rsc_n;
        end
    end
endmodule

// File: tb/tb_prbs64_checker.sv
// tb_prbs64_checker
//   Directed bench for prbs64_checker: local transmitter, behavioural
//   checker model feeding a scoreboard queue, per-cycle output comparison.
module tb_prbs64_checker;
    logic        clk = 1'b0;
    logic        reset, bit_in, bit_valid, clear;
    logic        locked, err_pulse;
    logic [31:0] err_count;
    logic [15:0] resync_count;

    always #5 clk = ~clk;

    prbs64_checker #(.ERR_THRESH(8), .WINDOW(256)) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear(clear), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .resync_count(resync_count)
    );

    typedef struct packed {
        logic        lk;
        logic        pl;
        logic [31:0] ec;
        logic [15:0] rc;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    logic [63:0] s;          // transmitter
    bit          m_locked;
    int          m_fill, m_wbits, m_werrs, vbits;
    logic [63:0] m_hist;
    logic [31:0] m_errc;
    logic [15:0] m_rsc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_locked = 0; m_fill = 0; m_wbits = 0; m_werrs = 0; vbits = 0;
        m_hist = '0; m_errc = '0; m_rsc = '0;
        sb.delete();
    endtask

    task automatic tx_bit(output logic b);
        s = {s[62:0], ~(s[63] ^ s[62] ^ s[60] ^ s[59])};
        b = s[0];
    endtask

    // Drive one cycle; err marks a bit deliberately corrupted on the line.
    task automatic drive(input bit v, input logic b, input bit err);
        exp_t e;
        bit   pulse;
        pulse     = 0;
        bit_valid = v;
        bit_in    = b;
        if (v) begin
            vbits++;
            if (!m_locked) begin
                m_hist = {m_hist[62:0], b};
                m_fill++;
                if (m_fill == 64) begin
                    m_fill = 0;
                    if (m_hist != '1) begin
                        m_locked = 1; m_wbits = 0; m_werrs = 0;
                    end
                end
            end else begin
                pulse = err;
                if (err) begin m_errc++; m_werrs++; end
                if (err && m_werrs >= 8) begin
                    m_locked = 0; m_fill = 0; m_rsc++; m_wbits = 0; m_werrs = 0;
                end else begin
                    m_wbits++;
                    if (m_wbits == 256) begin m_wbits = 0; m_werrs = 0; end
                end
            end
        end
        if (clear) begin m_errc = '0; m_rsc = '0; end
        e = '{lk: m_locked, pl: pulse, ec: m_errc, rc: m_rsc};
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("locked", 32'(locked), 32'(e.lk));
        chk("err_pulse", 32'(err_pulse), 32'(e.pl));
        chk("err_count", err_count, e.ec);
        chk("resync_count", 32'(resync_count), 32'(e.rc));
    endtask

    task automatic tx(input bit v, input bit flip);
        logic b;
        if (v) begin
            tx_bit(b);
            drive(1, b ^ flip, flip);
        end else begin
            drive(0, 1'($urandom_range(0, 1)), 0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_pulse"}, 32'(err_pulse), 0);
        chk({tag, "_errc"}, err_count, 0);
        chk({tag, "_rsc"}, 32'(resync_count), 0);
    endtask

    task automatic do_reset(input bit reseed);
        @(posedge clk); #3;
        reset = 1'b0;
        #1 chk_zero("rst_async");
        bit_valid = 1'b1; bit_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_zero("rst_hold");
        reset = 1'b1;
        bit_valid = 1'b0;
        model_reset();
        if (reseed) s = 64'h1;
    endtask

    initial begin
        int lockv, np;
        reset = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
        s = 64'h1;
        model_reset();
        #12 chk_zero("por");

        // continuous stream, lock at 64th bit, 10000 clean bits
        do_reset(1);
        repeat (63) tx(1, 0);
        chk("pre_lock", 32'(locked), 0);
        tx(1, 0);
        chk("lock_64", 32'(locked), 1);
        repeat (9936) tx(1, 0);
        chk("clean_10k", err_count, 0);

        // random bit_valid gaps
        do_reset(1);
        lockv = -1;
        repeat (2000) begin
            tx(bit'($urandom_range(0, 1)), 0);
            if (lockv < 0 && locked) lockv = vbits;
        end
        chk("lock_point_gaps", 32'(lockv), 64);
        chk("gaps_errc", err_count, 0);

        // single flip at valid bit 200
        do_reset(1);
        np = 0;
        for (int i = 1; i <= 400; i++) begin
            tx(1, i == 200);
            np += int'(err_pulse);
        end
        chk("single_pulses", 32'(np), 1);
        chk("single_errc", err_count, 1);
        chk("single_locked", 32'(locked), 1);

        // 8 flips within one window -> unlock, relock 64 bits later
        do_reset(1);
        repeat (84) tx(1, 0);
        for (int k = 0; k < 8; k++) begin
            repeat (4) tx(1, 0);
            tx(1, 1);
        end
        chk("thresh_unlock", 32'(locked), 0);
        chk("thresh_rsc", 32'(resync_count), 1);
        repeat (63) tx(1, 0);
        chk("relock_pre", 32'(locked), 0);
        tx(1, 0);
        chk("relock_64", 32'(locked), 1);
        repeat (300) tx(1, 0);
        chk("thresh_errc", err_count, 8);

        // 7 flips at end of a window + 7 at start of the next
        do_reset(1);
        repeat (64) tx(1, 0);
        repeat (249) tx(1, 0);
        repeat (14) tx(1, 1);
        chk("split_locked", 32'(locked), 1);
        chk("split_errc", err_count, 14);
        chk("split_rsc", 32'(resync_count), 0);
        // 8th error in this window coincides with clear
        clear = 1'b1;
        tx(1, 1);
        clear = 1'b0;
        chk("clr_errc", err_count, 0);
        chk("clr_rsc", 32'(resync_count), 0);
        chk("clr_unlock", 32'(locked), 0);

        // stuck-high line never locks
        do_reset(1);
        repeat (300) drive(1, 1'b1, 0);
        chk("stuck_locked", 32'(locked), 0);

        // reset mid-fill, fresh fill from next valid bit
        repeat (20) tx(1, 0);
        do_reset(0);
        repeat (63) tx(1, 0);
        chk("fresh_pre", 32'(locked), 0);
        tx(1, 0);
        chk("fresh_lock", 32'(locked), 1);
        repeat (200) tx(1, 0);
        chk("fresh_errc", err_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/prbs64_checker.md
PRBS64_CHECKER -- requirements
Module: prbs64_checker

Interface
REQ-001 Parameter: ERR_THRESH, 8, errors within one window that force loss of lock (legal range 1..WINDOW).
REQ-002 Parameter: WINDOW, 256, number of valid bits per error-evaluation window (legal range 64..65535).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 bit_in  input  1  received stream bit.
REQ-006 bit_valid  input  1  bit_in is sampled on a rising clk edge only when high.
REQ-007 clear  input  1  synchronous clear of err_count and resync_count.
REQ-008 locked  output  1  checker is synchronized to the stream.
REQ-009 err_pulse  output  1  one-cycle pulse per mismatched bit.
REQ-010 err_count  output  32  total mismatches while locked, saturating.
REQ-011 resync_count  output  16  number of LOCKED->FILL transitions caused by errors, saturating.

Function
REQ-012 The stream format SHALL be: transmitter register s shifts left each step, new bit = s[63] XNOR s[62] XNOR s[60] XNOR s[59] enters s[0]; the transmitted bit is that new bit.
REQ-013 The checker SHALL hold a 64-bit register r, a fill counter (0..63), a window bit counter and a window error counter.
REQ-014 States SHALL be FILL and LOCKED.
REQ-015 FILL: each valid bit SHALL shift in as r <= {r[62:0], bit_in}; no comparisons are made and err_pulse stays 0.
REQ-016 FILL->LOCKED SHALL occur on the edge sampling the 64th valid bit, unless the resulting r is all ones.
REQ-017 If the 64th fill bit makes r all ones (XNOR lock-up state), the checker SHALL restart the fill count at 0 and remain in FILL.
REQ-018 LOCKED: per valid bit, predicted p = r[63] XNOR r[62] XNOR r[60] XNOR r[59]; r SHALL shift in p, not bit_in (self-running, no error propagation).
REQ-019 On mismatch (bit_in != p), err_pulse SHALL be 1 in the cycle after the sampling edge; err_count and the window error count SHALL increment.
REQ-020 Window: the window bit counter SHALL count valid bits in LOCKED; on the WINDOWth bit, both window counters SHALL reset to 0 after that bit's error is evaluated.
REQ-021 If the window error count including the current bit reaches ERR_THRESH, the checker SHALL enter FILL on that edge, clear the fill and window counters and increment resync_count; this check takes precedence over the window reset in the same cycle.
REQ-022 locked SHALL equal (state == LOCKED) as a registered output.
REQ-023 bit_valid low SHALL freeze all state; err_pulse SHALL be 0 in the following cycle.
REQ-024 clear SHALL zero err_count and resync_count; if an increment coincides with clear, the result SHALL be 0.
REQ-025 err_count SHALL saturate at 0xFFFFFFFF and resync_count at 0xFFFF.

Reset
REQ-026 While reset is low, the checker SHALL set state=FILL, r=0, all counters=0, locked=0, err_pulse=0, err_count=0 and resync_count=0, asynchronously.
REQ-027 Reset deasserted mid-stream SHALL start a fresh 64-bit fill from the next valid bit.
REQ-028 The checker SHALL NOT act on clk edges while reset is low.

Verification
REQ-029 Transmitter seeded 64'h0000_0000_0000_0001 with continuous valid -> locked rises after the 64th valid bit; err_count stays 0 for 10000 bits.
REQ-030 bit_valid toggling pseudo-randomly with the same stream -> identical lock point in valid-bit terms; zero errors.
REQ-031 Single bit flipped at valid bit 200 -> exactly one err_pulse cycle; err_count=1; locked stays 1; no further errors.
REQ-032 8 flips within one 256-bit window -> locked falls after the 8th error; resync_count=1; relock 64 valid bits later; err_count=8.
REQ-033 7 flips at the end of window N plus 7 at the start of window N+1 -> no unlock; err_count=14.
REQ-034 All-ones fill (stuck transmitter) -> locked stays 0 indefinitely; reset pulsed low mid-fill -> all outputs 0 immediately.
